// File: rtl/flappy_pkg.sv
// Shared types, geometry defaults and BCD helper for the flappy datapath.
package flappy_pkg;

    // One-hot game-control states
    typedef enum logic [2:0] {
        S_INIT  = 3'b001,
        S_COUNT = 3'b010,
        S_STOP  = 3'b100
    } state_e;

    // Default playfield geometry
    localparam int unsigned SCREEN_W         = 640;
    localparam int unsigned PIPE_WIDTH_DEF   = 61;
    localparam int unsigned PIPE_SPACING_DEF = 142;
    localparam int unsigned BIRD_X_DEF       = 230;

    // Passes between speed increments when the ramp is built in
    localparam int unsigned RAMP_PASSES      = 8;

    // Increment one BCD digit with carry-in; returns {carry_out, digit}
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit, input logic cin);
        logic [4:0] res;
        if (!cin) begin
            res = {1'b0, digit};
        end else if (digit >= 4'd9) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, digit + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD counter with synchronous clear; wraps from all-9s to zero.
module bcd_score_counter
    import flappy_pkg::*;
#(
    parameter int unsigned SCORE_DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        inc,
    output logic [4*SCORE_DIGITS-1:0]   score
);

    logic [4*SCORE_DIGITS-1:0] score_q, score_d;
    logic                      carry;
    logic [4:0]                digit_res;

    // Ripple the increment through the digits, least significant first
    always_comb begin
        score_d   = score_q;
        carry     = inc;
        digit_res = '0;
        if (clear) begin
            score_d = '0;
        end else begin
            for (int unsigned d = 0; d < SCORE_DIGITS; d++) begin
                digit_res              = bcd_digit_inc(score_q[d*4 +: 4], carry);
                score_d[d*4 +: 4]      = digit_res[3:0];
                carry                  = digit_res[4];
            end
        end
    end

    // Score register
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/pipe_scroller.sv
// Pipe X-coordinate engine: scrolls NUM_PIPES pipes left on each frame tick,
// respawns expired pipes behind the field, tracks the in-scope pipe and score.
// Optional feature macro: SPEED_RAMP_EN (latched step that ramps up with passes).
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES    = 5,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned PIPE_WIDTH   = PIPE_WIDTH_DEF,
    parameter int unsigned PIPE_SPACING = PIPE_SPACING_DEF,
    parameter int unsigned BIRD_X       = BIRD_X_DEF,
    parameter int unsigned FIRST_PIPE   = 2,
    parameter int unsigned SCORE_DIGITS = 2,
    parameter int unsigned STEP_W       = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           ack,
    input  logic                           tick,
    input  logic [STEP_W-1:0]              speed,
    output logic [NUM_PIPES*COORD_W-1:0]   edge_l,
    output logic [NUM_PIPES*COORD_W-1:0]   edge_r,
    output logic [2:0]                     out_pipe,
    output logic [4*SCORE_DIGITS-1:0]      score,
    output logic                           pass_pulse,
    output logic                           q_initial,
    output logic                           q_count,
    output logic                           q_stop
);

    localparam int unsigned IDX_W = 3;

    typedef logic [COORD_W-1:0] coord_t;

    state_e            state_q, state_d;
    coord_t            left_q  [NUM_PIPES];
    coord_t            left_d  [NUM_PIPES];
    coord_t            right_q [NUM_PIPES];
    coord_t            right_d [NUM_PIPES];
    logic [IDX_W-1:0]  out_pipe_q, out_pipe_d;
    logic              pass_pulse_q, pass_pulse_d;

    logic              pass_now;
    logic              start_now;
    logic              score_clear;
    logic [STEP_W-1:0] step;
    coord_t            step_c;
    logic [IDX_W:0]    slot_idx;

`ifdef SPEED_RAMP_EN
    localparam int unsigned RAMP_W = $clog2(RAMP_PASSES);

    logic [STEP_W-1:0] step_q, step_d;
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;

    // Latch speed at game start, then bump it every RAMP_PASSES passes
    always_comb begin
        step_d     = step_q;
        ramp_cnt_d = ramp_cnt_q;
        if (start_now) begin
            step_d     = speed;
            ramp_cnt_d = '0;
        end else if (pass_now) begin
            if (ramp_cnt_q == RAMP_W'(RAMP_PASSES - 1)) begin
                ramp_cnt_d = '0;
                if (step_q != '1) begin
                    step_d = step_q + 1'b1;
                end
            end else begin
                ramp_cnt_d = ramp_cnt_q + 1'b1;
            end
        end
    end

    // Ramp registers
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q     <= '0;
            ramp_cnt_q <= '0;
        end else begin
            step_q     <= step_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign step = step_q;
`else
    assign step = speed;
`endif

    assign step_c    = COORD_W'(step);
    assign start_now = (state_q == S_INIT) && start;

    // Next-state and coordinate update; every pipe uses pre-update values only
    always_comb begin
        state_d      = state_q;
        left_d       = left_q;
        right_d      = right_q;
        out_pipe_d   = out_pipe_q;
        pass_pulse_d = 1'b0;
        pass_now     = 1'b0;
        score_clear  = 1'b0;
        case (state_q)
            S_INIT: begin
                for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                    left_d[i]  = COORD_W'(i * PIPE_SPACING);
                    right_d[i] = COORD_W'(i * PIPE_SPACING + PIPE_WIDTH);
                end
                out_pipe_d  = IDX_W'(FIRST_PIPE);
                score_clear = 1'b1;
                if (start) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (stop) begin
                    state_d = S_STOP;
                end else if (tick) begin
                    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                        if (right_q[i] <= step_c) begin
                            // Anchor on the predecessor's old left so spacing stays exact
                            left_d[i]  = left_q[(i + NUM_PIPES - 1) % NUM_PIPES]
                                         + COORD_W'(PIPE_SPACING) - step_c;
                            right_d[i] = left_q[(i + NUM_PIPES - 1) % NUM_PIPES]
                                         + COORD_W'(PIPE_SPACING + PIPE_WIDTH) - step_c;
                        end else begin
                            right_d[i] = right_q[i] - step_c;
                            left_d[i]  = (left_q[i] > step_c) ? (left_q[i] - step_c) : '0;
                        end
                    end
                    if (right_q[out_pipe_q] < COORD_W'(BIRD_X)) begin
                        pass_now     = 1'b1;
                        pass_pulse_d = 1'b1;
                        out_pipe_d   = (out_pipe_q == IDX_W'(NUM_PIPES - 1)) ? '0
                                                                             : out_pipe_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (ack) begin
                    state_d = S_INIT;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State, coordinate and index registers; reset loads the INIT values directly
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            pass_pulse_q <= 1'b0;
            out_pipe_q   <= IDX_W'(FIRST_PIPE);
            for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                left_q[i]  <= COORD_W'(i * PIPE_SPACING);
                right_q[i] <= COORD_W'(i * PIPE_SPACING + PIPE_WIDTH);
            end
        end else begin
            state_q      <= state_d;
            pass_pulse_q <= pass_pulse_d;
            out_pipe_q   <= out_pipe_d;
            left_q       <= left_d;
            right_q      <= right_d;
        end
    end

    bcd_score_counter #(
        .SCORE_DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (pass_now),
        .score (score)
    );

    // Reorder edges so slot 0 is the in-scope pipe, then outward
    always_comb begin
        edge_l   = '0;
        edge_r   = '0;
        slot_idx = '0;
        for (int unsigned k = 0; k < NUM_PIPES; k++) begin
            slot_idx = {1'b0, out_pipe_q} + (IDX_W + 1)'(k);
            if (slot_idx >= (IDX_W + 1)'(NUM_PIPES)) begin
                slot_idx = slot_idx - (IDX_W + 1)'(NUM_PIPES);
            end
            edge_l[k*COORD_W +: COORD_W] = left_q[slot_idx[IDX_W-1:0]];
            edge_r[k*COORD_W +: COORD_W] = right_q[slot_idx[IDX_W-1:0]];
        end
    end

    assign out_pipe   = out_pipe_q;
    assign pass_pulse = pass_pulse_q;
    assign q_initial  = (state_q == S_INIT);
    assign q_count    = (state_q == S_COUNT);
    assign q_stop     = (state_q == S_STOP);

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: a behavioural model pushes the expected
// post-edge outputs each cycle; they are popped and compared after the edge.
module tb_pipe_scroller;

    localparam int NP  = 5;
    localparam int CW  = 10;
    localparam int PW  = 61;
    localparam int SPC = 142;
    localparam int BX  = 230;
    localparam int FP  = 2;
    localparam int SW  = 3;
    localparam int SD  = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              ack;
    logic              tick;
    logic [SW-1:0]     speed;
    logic [NP*CW-1:0]  edge_l;
    logic [NP*CW-1:0]  edge_r;
    logic [2:0]        out_pipe;
    logic [4*SD-1:0]   score;
    logic              pass_pulse;
    logic              q_initial;
    logic              q_count;
    logic              q_stop;

    pipe_scroller #(
        .NUM_PIPES    (NP),
        .COORD_W      (CW),
        .PIPE_WIDTH   (PW),
        .PIPE_SPACING (SPC),
        .BIRD_X       (BX),
        .FIRST_PIPE   (FP),
        .SCORE_DIGITS (SD),
        .STEP_W       (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .ack        (ack),
        .tick       (tick),
        .speed      (speed),
        .edge_l     (edge_l),
        .edge_r     (edge_r),
        .out_pipe   (out_pipe),
        .score      (score),
        .pass_pulse (pass_pulse),
        .q_initial  (q_initial),
        .q_count    (q_count),
        .q_stop     (q_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model
    int m_left[NP];
    int m_right[NP];
    int m_outp, m_score, m_state, m_step, m_rcnt;
    bit m_pulse, m_full;

    typedef struct {
        bit               full;
        logic [2:0]       st;
        logic [NP*CW-1:0] el;
        logic [NP*CW-1:0] er;
        logic [2:0]       op;
        logic [4*SD-1:0]  sc;
        logic             pp;
    } exp_t;

    exp_t sbq[$];

    function automatic logic [NP*CW-1:0] pack_l();
        logic [NP*CW-1:0] v;
        for (int k = 0; k < NP; k++) v[k*CW +: CW] = CW'(m_left[(m_outp + k) % NP]);
        return v;
    endfunction

    function automatic logic [NP*CW-1:0] pack_r();
        logic [NP*CW-1:0] v;
        for (int k = 0; k < NP; k++) v[k*CW +: CW] = CW'(m_right[(m_outp + k) % NP]);
        return v;
    endfunction

    function automatic logic [7:0] bcd_of(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int dut_l(input int k);
        return int'(edge_l[k*CW +: CW]);
    endfunction

    function automatic int dut_r(input int k);
        return int'(edge_r[k*CW +: CW]);
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit sp, input bit ak,
                              input bit tk, input int spd);
        int nl[NP];
        int nr[NP];
        int s;
        if (rst) begin
            m_state = 0;
            m_pulse = 0;
            m_full  = 0;
            return;
        end
        m_pulse = 0;
        case (m_state)
            0: begin
                for (int i = 0; i < NP; i++) begin
                    m_left[i]  = i * SPC;
                    m_right[i] = i * SPC + PW;
                end
                m_outp  = FP;
                m_score = 0;
                m_full  = 1;
                if (st) begin
                    m_state = 1;
                    m_step  = spd;
                    m_rcnt  = 0;
                end
            end
            1: begin
                if (sp) begin
                    m_state = 2;
                end else if (tk) begin
`ifdef SPEED_RAMP_EN
                    s = m_step;
`else
                    s = spd;
`endif
                    for (int i = 0; i < NP; i++) begin
                        if (m_right[i] <= s) begin
                            nl[i] = m_left[(i + NP - 1) % NP] - s + SPC;
                            nr[i] = nl[i] + PW;
                        end else begin
                            nr[i] = m_right[i] - s;
                            nl[i] = (m_left[i] > s) ? m_left[i] - s : 0;
                        end
                    end
                    if (m_right[m_outp] < BX) begin
                        m_outp  = (m_outp + 1) % NP;
                        m_score = (m_score + 1) % 100;
                        m_pulse = 1;
                        m_rcnt++;
                        if (m_rcnt == 8) begin
                            m_rcnt = 0;
                            if (m_step < 7) m_step++;
                        end
                    end
                    for (int i = 0; i < NP; i++) begin
                        m_left[i]  = nl[i];
                        m_right[i] = nr[i];
                    end
                end
            end
            default: begin
                if (ak) m_state = 0;
            end
        endcase
    endtask

    // Drive one cycle, push the model's expectation, pop and compare after the edge
    task automatic cycle(input bit rst, input bit st, input bit sp, input bit ak,
                         input bit tk, input int spd);
        exp_t e;
        reset = rst;
        start = st;
        stop  = sp;
        ack   = ak;
        tick  = tk;
        speed = SW'(spd);
        model_step(rst, st, sp, ak, tk, spd);
        e.full = m_full;
        e.st   = (m_state == 0) ? 3'b001 : (m_state == 1) ? 3'b010 : 3'b100;
        e.el   = pack_l();
        e.er   = pack_r();
        e.op   = 3'(m_outp);
        e.sc   = bcd_of(m_score);
        e.pp   = m_pulse;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_val("state", 64'({q_stop, q_count, q_initial}), 64'(e.st));
        check_val("pass_pulse", 64'(pass_pulse), 64'(e.pp));
        if (e.full) begin
            check_val("edge_l", 64'(edge_l), 64'(e.el));
            check_val("edge_r", 64'(edge_r), 64'(e.er));
            check_val("out_pipe", 64'(out_pipe), 64'(e.op));
            check_val("score", 64'(score), 64'(e.sc));
        end
    endtask

    task automatic check_init_values(input string tag);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (FP + k) % NP;
            check_val({tag, "_l"}, 64'(dut_l(k)), 64'(p * SPC));
            check_val({tag, "_r"}, 64'(dut_r(k)), 64'(p * SPC + PW));
        end
        check_val({tag, "_outp"}, 64'(out_pipe), 64'(FP));
        check_val({tag, "_score"}, 64'(score), 64'(0));
        check_val({tag, "_qinit"}, 64'(q_initial), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int l4_old, s0, s4;
        logic [NP*CW-1:0] saved_l;

        reset = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0; tick = 1'b0; speed = '0;
        m_state = 0; m_full = 0; m_pulse = 0; m_outp = FP; m_score = 0; m_step = 0; m_rcnt = 0;

        // Reset, then one INIT cycle; start/stop/ack ignored apart from start
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 1, 3);
        check_init_values("init");

        // Start, then 10 ticks at speed 1
        cycle(0, 1, 0, 0, 0, 1);
        for (int t = 0; t < 10; t++) cycle(0, 0, 0, 0, 1, 1);
        check_val("scroll_slot0_l", 64'(dut_l(0)), 64'(274));
        check_val("scroll_slot0_r", 64'(dut_r(0)), 64'(335));
        check_val("scroll_pipe0_l", 64'(dut_l(3)), 64'(0));
        check_val("scroll_pipe0_r", 64'(dut_r(3)), 64'(51));

        // First pass at speed 1 with irregular ticks
        guard = 0;
        while (!m_pulse && guard < 2000) begin
            cycle(0, 0, 0, 0, ($urandom_range(0, 3) != 0), 1);
            guard++;
        end
        check_val("pass1_pulse", 64'(pass_pulse), 64'(1));
        check_val("pass1_outp", 64'(out_pipe), 64'(3));
        check_val("pass1_score", 64'(score), 64'(8'h01));
        cycle(0, 0, 0, 0, 1, 1);
        check_val("pass1_single", 64'(pass_pulse), 64'(0));

        // Continue to ten passes
        guard = 0;
        while (m_score < 10 && guard < 3000) begin
            cycle(0, 0, 0, 0, ($urandom_range(0, 4) != 0), 1);
            guard++;
        end
        check_val("ten_passes", 64'(score), 64'(8'h10));

        // Paused field at speed 0
        for (int t = 0; t < 4; t++) cycle(0, 0, 0, 0, 1, 0);

        // Respawn spacing at speed 3
        guard = 0;
        while (m_right[0] > 3 && guard < 1000) begin
            cycle(0, 0, 0, 0, 1, 3);
            guard++;
        end
        l4_old = m_left[4];
        cycle(0, 0, 0, 0, 1, 3);
        s0 = (0 + NP - m_outp) % NP;
        s4 = (4 + NP - m_outp) % NP;
        check_val("respawn_l0", 64'(dut_l(s0)), 64'(l4_old - 3 + SPC));
        check_val("respawn_r0", 64'(dut_r(s0)), 64'(l4_old - 3 + SPC + PW));
        check_val("respawn_gap", 64'(dut_l(s0) - dut_l(s4)), 64'(SPC));

        // Stop wins over tick; field frozen in STOP; ack returns to INIT
        saved_l = pack_l();
        cycle(0, 0, 1, 0, 1, 3);
        check_val("stop_q", 64'(q_stop), 64'(1));
        check_val("stop_frozen", 64'(edge_l), 64'(saved_l));
        for (int t = 0; t < 3; t++) cycle(0, 1, 0, 0, 1, 5);
        check_val("stop_hold", 64'(edge_l), 64'(saved_l));
        cycle(0, 0, 0, 1, 1, 3);
        cycle(0, 0, 0, 0, 0, 0);
        check_init_values("ack_init");

        // Score wrap from 99 to 00 at speed 7
        cycle(0, 1, 0, 0, 0, 7);
        guard = 0;
        while (m_score != 99 && guard < 4000) begin
            cycle(0, 0, 0, 0, 1, 7);
            guard++;
        end
        check_val("score_99", 64'(score), 64'(8'h99));
        guard = 0;
        do begin
            cycle(0, 0, 0, 0, 1, 7);
            guard++;
        end while (!m_pulse && guard < 200);
        check_val("wrap_pulse", 64'(pass_pulse), 64'(1));
        check_val("wrap_score", 64'(score), 64'(8'h00));

        // Reset while a pass is pending on a tick
        guard = 0;
        while (m_right[m_outp] >= BX && guard < 200) begin
            cycle(0, 0, 0, 0, 1, 2);
            guard++;
        end
        cycle(1, 0, 0, 0, 1, 2);
        check_val("rst_pulse", 64'(pass_pulse), 64'(0));
        check_val("rst_qinit", 64'(q_initial), 64'(1));
        cycle(0, 0, 0, 0, 0, 0);
        check_val("rst_score", 64'(score), 64'(8'h00));
        check_val("rst_outp", 64'(out_pipe), 64'(FP));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
